// File: rtl/jt89_wrseq.sv
// jt89_wrseq: two-requester byte write sequencer and round-robin arbiter for the jt89 PSG bus.
// Define JT89_WRSEQ_LOCK_EN to keep a tone latch byte and its data byte atomic per requester.
module jt89_wrseq #(
    parameter int WR_LEN  = 2,
    parameter int LOCK_TO = 255
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       a_req,
    input  logic [7:0] a_din,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [7:0] b_din,
    output logic       b_ack,
    input  logic       psg_ready,
    output logic       psg_wr_n,
    output logic       psg_ce_n,
    output logic [7:0] psg_din,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, WRITE, GUARD, WAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       prio_b_q, prio_b_d;
    logic [7:0] din_q, din_d;
    logic       a_ack_q, a_ack_d;
    logic       b_ack_q, b_ack_d;
    logic       wr_n_q, wr_n_d;
    logic       busy_q, busy_d;
    logic       a_elig, b_elig;
    logic       gnt_a, gnt_b;
    logic       lock_busy_d;

`ifdef JT89_WRSEQ_LOCK_EN
    logic       lock_q, lock_d;
    logic       own_b_q, own_b_d;
    logic [7:0] lcnt_q, lcnt_d;
    logic       lock_eff;
    logic       latch_byte;

    // An expired counter releases the lock in the same cycle, so the other side may be granted.
    assign lock_eff   = lock_q && (lcnt_q != 8'd0);
    assign a_elig     = a_req && psg_ready && (!lock_eff || !own_b_q);
    assign b_elig     = b_req && psg_ready && (!lock_eff || own_b_q);
    assign latch_byte = din_d[7] && !din_d[4] && (din_d[6:5] != 2'b11);

    always_comb begin
        lock_d  = lock_q;
        own_b_d = own_b_q;
        lcnt_d  = lcnt_q;
        if (gnt_a || gnt_b) begin
            lock_d  = latch_byte;
            own_b_d = gnt_b;
            lcnt_d  = 8'(LOCK_TO);
        end else if (lock_q) begin
            if (lcnt_q == 8'd0) lock_d = 1'b0;
            else                lcnt_d = lcnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q  <= 1'b0;
            own_b_q <= 1'b0;
            lcnt_q  <= 8'd0;
        end else begin
            lock_q  <= lock_d;
            own_b_q <= own_b_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign lock_busy_d = lock_d;
`else
    assign a_elig      = a_req && psg_ready;
    assign b_elig      = b_req && psg_ready;
    assign lock_busy_d = 1'b0;

    // The timeout is meaningless without the lock; referenced so both builds share one parameter list.
    if (LOCK_TO < 0) begin : g_no_lock
    end
`endif

    assign gnt_a = (state_q == IDLE) && a_elig && (!b_elig || !prio_b_q);
    assign gnt_b = (state_q == IDLE) && b_elig && (!a_elig || prio_b_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            prio_b_q <= 1'b0;
            din_q    <= 8'd0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            wr_n_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prio_b_q <= prio_b_d;
            din_q    <= din_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            wr_n_q   <= wr_n_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_a || gnt_b) begin
                    state_d = WRITE;
                    cnt_d   = 4'd0;
                end
            end
            WRITE: begin
                if (cnt_q == 4'(WR_LEN - 1)) state_d = GUARD;
                else                         cnt_d   = cnt_q + 4'd1;
            end
            GUARD:   state_d = WAIT;
            WAIT:    if (psg_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so wr_n drops in the cycle right after the grant.
    always_comb begin
        prio_b_d = prio_b_q;
        din_d    = din_q;
        if (gnt_a) begin
            prio_b_d = 1'b1;
            din_d    = a_din;
        end else if (gnt_b) begin
            prio_b_d = 1'b0;
            din_d    = b_din;
        end
        a_ack_d = gnt_a;
        b_ack_d = gnt_b;
        wr_n_d  = (state_d != WRITE);
        busy_d  = (state_d != IDLE) || lock_busy_d;
    end

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign psg_wr_n = wr_n_q;
    assign psg_ce_n = wr_n_q;
    assign psg_din  = din_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_jt89_wrseq.sv
// Directed self-checking bench for jt89_wrseq (WR_LEN=2, LOCK_TO=20); expectations follow the lock build macro.
module tb_jt89_wrseq;
    localparam int WR_LEN  = 2;
    localparam int LOCK_TO = 20;
`ifdef JT89_WRSEQ_LOCK_EN
    localparam logic [7:0] LK_B1 = 8'h12;
    localparam logic [7:0] LK_B2 = 8'h9F;
    localparam int         TO_DELTA = 21;
    localparam logic       TO_BUSY  = 1'b1;
`else
    localparam logic [7:0] LK_B1 = 8'h9F;
    localparam logic [7:0] LK_B2 = 8'h12;
    localparam int         TO_DELTA = 5;
    localparam logic       TO_BUSY  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_req = 1'b0, b_req = 1'b0;
    logic [7:0] a_din = 8'h00, b_din = 8'h00;
    logic       a_ack, b_ack;
    logic       psg_ready = 1'b1;
    logic       psg_wr_n, psg_ce_n, busy;
    logic [7:0] psg_din;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [7:0] wlog[$];
    logic       wr_n_prev = 1'b1;
    int         rdy_cnt = 0;
    int         rdy_rise = -1;
    bit         rdy_mode = 1'b0;

    jt89_wrseq #(.WR_LEN(WR_LEN), .LOCK_TO(LOCK_TO)) dut (
        .rst(rst), .clk(clk),
        .a_req(a_req), .a_din(a_din), .a_ack(a_ack),
        .b_req(b_req), .b_din(b_din), .b_ack(b_ack),
        .psg_ready(psg_ready), .psg_wr_n(psg_wr_n), .psg_ce_n(psg_ce_n),
        .psg_din(psg_din), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write logger and jt89-like ready model: ready stays low for 32 cycles after wr_n returns high.
    always @(negedge clk) begin
        if (!psg_wr_n && wr_n_prev) wlog.push_back(psg_din);
        wr_n_prev = psg_wr_n;
        if (rst || !rdy_mode) begin
            rdy_cnt = 0;
            psg_ready = 1'b1;
        end else if (!psg_wr_n) begin
            rdy_cnt = 32;
            psg_ready = 1'b0;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) begin
                psg_ready = 1'b1;
                rdy_rise = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_din = 8'h00; b_din = 8'h00; rdy_mode = 1'b0;
        step();
        step();
        rst = 1'b0;
        wlog.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0; rdy_mode = 1'b0;
        step();
        step();
        n_chk++; if (psg_wr_n !== 1'b1) $display("FAIL reset_wr_n: got %b want 1", psg_wr_n); else n_pass++;
        n_chk++; if (psg_ce_n !== 1'b1) $display("FAIL reset_ce_n: got %b want 1", psg_ce_n); else n_pass++;
        n_chk++; if (psg_din !== 8'h00) $display("FAIL reset_din: got %h want 00", psg_din); else n_pass++;
        n_chk++; if (a_ack !== 1'b0) $display("FAIL reset_a_ack: got %b want 0", a_ack); else n_pass++;
        n_chk++; if (b_ack !== 1'b0) $display("FAIL reset_b_ack: got %b want 0", b_ack); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        rst = 1'b0;
        step();
        n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_write();
        int  t_ack;
        bit  seen;
        do_reset();
        rdy_mode = 1'b1;
        rdy_rise = -1;
        a_req = 1'b1; a_din = 8'h9F;
        step();
        n_chk++; if (a_ack !== 1'b1) $display("FAIL single_ack: got %b want 1", a_ack); else n_pass++;
        n_chk++; if (psg_wr_n !== 1'b0) $display("FAIL single_wr_n1: got %b want 0", psg_wr_n); else n_pass++;
        n_chk++; if (psg_ce_n !== 1'b0) $display("FAIL single_ce_n1: got %b want 0", psg_ce_n); else n_pass++;
        n_chk++; if (psg_din !== 8'h9F) $display("FAIL single_din: got %h want 9f", psg_din); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        a_req = 1'b0;
        step();
        n_chk++; if (psg_wr_n !== 1'b0) $display("FAIL single_wr_n2: got %b want 0", psg_wr_n); else n_pass++;
        n_chk++; if (a_ack !== 1'b0) $display("FAIL single_ack_pulse: got %b want 0", a_ack); else n_pass++;
        step();
        n_chk++; if (psg_wr_n !== 1'b1) $display("FAIL single_guard_wr_n: got %b want 1", psg_wr_n); else n_pass++;
        n_chk++; if (psg_din !== 8'h9F) $display("FAIL single_din_hold: got %h want 9f", psg_din); else n_pass++;
        a_req = 1'b1; a_din = 8'hBF;
        seen = 1'b0; t_ack = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (a_ack) begin
                seen = 1'b1; t_ack = cyc;
                break;
            end
        end
        a_req = 1'b0;
        n_chk++; if (!seen) $display("FAIL single_second_ack: got none want ack within 60 cycles"); else n_pass++;
        n_chk++; if (t_ack - rdy_rise !== 2) $display("FAIL single_ready_wait: ack-ready_rise got %0d want 2", t_ack - rdy_rise); else n_pass++;
    endtask

    task automatic test_fairness();
        int acks_a[$];
        int acks_b[$];
        do_reset();
        a_req = 1'b1; a_din = 8'h90;
        b_req = 1'b1; b_din = 8'hB0;
        for (int i = 0; i < 40 && wlog.size() < 4; i++) begin
            step();
            if (a_ack) acks_a.push_back(cyc);
            if (b_ack) acks_b.push_back(cyc);
        end
        a_req = 1'b0; b_req = 1'b0;
        n_chk++; if (wlog.size() !== 4) $display("FAIL fair_count: got %0d want 4", wlog.size()); else n_pass++;
        n_chk++; if (wlog[0] !== 8'h90) $display("FAIL fair_w0: got %h want 90", wlog[0]); else n_pass++;
        n_chk++; if (wlog[1] !== 8'hB0) $display("FAIL fair_w1: got %h want b0", wlog[1]); else n_pass++;
        n_chk++; if (wlog[2] !== 8'h90) $display("FAIL fair_w2: got %h want 90", wlog[2]); else n_pass++;
        n_chk++; if (wlog[3] !== 8'hB0) $display("FAIL fair_w3: got %h want b0", wlog[3]); else n_pass++;
        n_chk++; if (acks_a.size() !== 2 || acks_b.size() !== 2)
            $display("FAIL fair_acks: got a=%0d b=%0d want 2 2", acks_a.size(), acks_b.size()); else n_pass++;
        n_chk++; if (acks_b[0] - acks_a[0] !== WR_LEN + 3)
            $display("FAIL fair_spacing: got %0d want %0d", acks_b[0] - acks_a[0], WR_LEN + 3); else n_pass++;
        n_chk++; if (acks_b[1] - acks_a[0] !== 3 * (WR_LEN + 3))
            $display("FAIL fair_span: got %0d want %0d", acks_b[1] - acks_a[0], 3 * (WR_LEN + 3)); else n_pass++;
    endtask

    task automatic test_lock_order();
        int na;
        do_reset();
        na = 0;
        a_req = 1'b1; a_din = 8'h85;
        for (int i = 0; i < 40 && wlog.size() < 3; i++) begin
            step();
            if (a_ack) begin
                na++;
                if (na == 1) begin
                    a_din = 8'h12;
                    b_req = 1'b1; b_din = 8'h9F;
                end else begin
                    a_req = 1'b0;
                end
            end
            if (b_ack) b_req = 1'b0;
        end
        a_req = 1'b0; b_req = 1'b0;
        n_chk++; if (wlog[0] !== 8'h85) $display("FAIL lock_w0: got %h want 85", wlog[0]); else n_pass++;
        n_chk++; if (wlog[1] !== LK_B1) $display("FAIL lock_w1: got %h want %h", wlog[1], LK_B1); else n_pass++;
        n_chk++; if (wlog[2] !== LK_B2) $display("FAIL lock_w2: got %h want %h", wlog[2], LK_B2); else n_pass++;
    endtask

    task automatic test_lock_timeout();
        int  ta, tbk;
        bit  seen;
        logic busy_mid;
        do_reset();
        ta = -1; tbk = -1; seen = 1'b0; busy_mid = 1'bx;
        a_req = 1'b1; a_din = 8'h85;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_ack) begin
                ta = cyc;
                break;
            end
        end
        a_req = 1'b0;
        b_req = 1'b1; b_din = 8'h9F;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cyc == ta + 4) busy_mid = busy;
            if (b_ack) begin
                seen = 1'b1; tbk = cyc;
                break;
            end
        end
        b_req = 1'b0;
        n_chk++; if (!seen) $display("FAIL timeout_b_ack: got none want ack within 40 cycles"); else n_pass++;
        n_chk++; if (tbk - ta !== TO_DELTA) $display("FAIL timeout_delay: got %0d want %0d", tbk - ta, TO_DELTA); else n_pass++;
        n_chk++; if (busy_mid !== TO_BUSY) $display("FAIL timeout_busy: got %b want %b", busy_mid, TO_BUSY); else n_pass++;
    endtask

    task automatic test_noise_no_lock();
        int ta, tbk;
        do_reset();
        ta = -1; tbk = -1;
        a_req = 1'b1; a_din = 8'hE4;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_ack) begin
                ta = cyc;
                break;
            end
        end
        a_req = 1'b0;
        b_req = 1'b1; b_din = 8'hF0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (b_ack) begin
                tbk = cyc;
                break;
            end
        end
        b_req = 1'b0;
        step();
        n_chk++; if (tbk - ta !== WR_LEN + 3) $display("FAIL noise_delay: got %0d want %0d", tbk - ta, WR_LEN + 3); else n_pass++;
        n_chk++; if (wlog[1] !== 8'hF0) $display("FAIL noise_w1: got %h want f0", wlog[1]); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        a_req = 1'b1; a_din = 8'h9F;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_ack) break;
        end
        a_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!busy) break;
        end
        a_req = 1'b1; a_din = 8'h90;
        b_req = 1'b1; b_din = 8'hB0;
        step();
        n_chk++; if (b_ack !== 1'b1 || psg_wr_n !== 1'b0)
            $display("FAIL rmid_pre: got b_ack=%b wr_n=%b want 1 0", b_ack, psg_wr_n); else n_pass++;
        rst = 1'b1;
        step();
        n_chk++; if (psg_wr_n !== 1'b1) $display("FAIL rmid_wr_n: got %b want 1", psg_wr_n); else n_pass++;
        n_chk++; if (psg_ce_n !== 1'b1) $display("FAIL rmid_ce_n: got %b want 1", psg_ce_n); else n_pass++;
        n_chk++; if (psg_din !== 8'h00) $display("FAIL rmid_din: got %h want 00", psg_din); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (b_ack !== 1'b0) $display("FAIL rmid_b_ack: got %b want 0", b_ack); else n_pass++;
        rst = 1'b0;
        step();
        n_chk++; if (a_ack !== 1'b1 || b_ack !== 1'b0)
            $display("FAIL rmid_prio: got a_ack=%b b_ack=%b want 1 0", a_ack, b_ack); else n_pass++;
        n_chk++; if (psg_din !== 8'h90) $display("FAIL rmid_din_after: got %h want 90", psg_din); else n_pass++;
        a_req = 1'b0; b_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fairness();
        test_lock_order();
        test_lock_timeout();
        test_noise_no_lock();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
